classify_ctrl: RTL

Sequencer for the final argmax stage of the BNN: collects `IC` signed Q8.8 class scores streamed one per beat from the FC layer, presents them as a parallel array to the argmax comparator, drives its level-sensitive enable, waits for its done flag, and returns the winning class index over a valid/ready handshake. It sits between the FC layer output and the top-level result interface. It also provides an optional watchdog against a hung comparator.

---
 rtl/classify_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/classify_ctrl.sv
// classify_ctrl: sequencer for the BNN argmax stage.
// Collects IC signed Q8.8 scores, one per beat, and presents them to the
// argmax comparator as a parallel array. It then enables the comparator,
// waits for its done flag and returns the winning class over a
// valid/ready handshake.
// Optional feature macro: CLASSIFY_CTRL_WATCHDOG_EN adds a RUN-state
// watchdog. On expiry the block reports class IC and raises a sticky error.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for the first score beat of a frame
// LOAD  | collecting beats 1..IC-1
// RUN   | comparator enabled; waiting for cmp_done (or watchdog expiry)
// HOLD  | result presented; waiting for class_ready
module classify_ctrl #(
  parameter int IC         = 10,
  parameter int OUTPUT_BIT = $clog2(IC + 1),
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  score_valid,
  input  logic signed [15:0]    score_in,
  output logic                  score_ready,
  output logic signed [15:0]    cmp_scores [0:IC-1],
  output logic                  cmp_start,
  input  logic                  cmp_done,
  input  logic [OUTPUT_BIT-1:0] cmp_class,
  output logic                  class_valid,
  output logic [OUTPUT_BIT-1:0] class_out,
  input  logic                  class_ready,
  output logic                  busy,
  output logic                  error
);

  localparam int CW = (IC > 1) ? $clog2(IC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [CW-1:0]           w_wr_idx;
  logic                    w_accept;
  logic                    w_wd_timeout;
  logic                    r_cmp_start;
  logic                    r_class_valid;
  logic [OUTPUT_BIT-1:0]   r_class_out, w_class_out_nxt;
  logic signed [15:0]      r_scores [0:IC-1];

  assign score_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign busy        = (r_state != S_IDLE);
  assign w_accept    = score_valid && score_ready;
  assign w_wr_idx    = (r_state == S_IDLE) ? '0 : r_cnt;
  assign cmp_start   = r_cmp_start;
  assign class_valid = r_class_valid;
  assign class_out   = r_class_out;
  assign cmp_scores  = r_scores;

  // Next-state, beat counter and result-capture decode
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_class_out_nxt = r_class_out;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (IC == 1) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_LOAD;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          if (r_cnt == CW'(IC - 1)) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_RUN: begin
        // A done flag in the same cycle as watchdog expiry takes priority.
        if (cmp_done) begin
          w_state_nxt     = S_HOLD;
          w_class_out_nxt = cmp_class;
        end else if (w_wd_timeout) begin
          w_state_nxt     = S_HOLD;
          w_class_out_nxt = OUTPUT_BIT'(IC);
        end
      end
      S_HOLD: begin
        if (class_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter and registered handshake/enable outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cmp_start   <= 1'b0;
      r_class_valid <= 1'b0;
      r_class_out   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cmp_start   <= (w_state_nxt == S_RUN);
      r_class_valid <= (w_state_nxt == S_HOLD);
      r_class_out   <= w_class_out_nxt;
    end
  end

  // Score array: never cleared between frames, each entry rewritten per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IC; i++) r_scores[i] <= '0;
    end else begin
      for (int i = 0; i < IC; i++) begin
        if (w_accept && (w_wr_idx == CW'(i))) r_scores[i] <= score_in;
      end
    end
  end

`ifdef CLASSIFY_CTRL_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] r_wd_cnt;
  logic          r_error;

  assign w_wd_timeout = (r_state == S_RUN) && (r_wd_cnt == WW'(TIMEOUT - 1));
  assign error        = r_error;

  // RUN-cycle counter; restarts whenever the block is outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state != S_RUN) begin
      r_wd_cnt <= '0;
    end else if (!w_wd_timeout) begin
      r_wd_cnt <= r_wd_cnt + WW'(1);
    end
  end

  // Sticky error: set on a real timeout, cleared by the next frame's first beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= 1'b0;
    end else if (w_wd_timeout && !cmp_done) begin
      r_error <= 1'b1;
    end else if (w_accept && (r_state == S_IDLE)) begin
      r_error <= 1'b0;
    end
  end
`else
  logic w_unused_timeout;

  assign w_wd_timeout     = 1'b0;
  assign error            = 1'b0;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

endmodule
